// File: rtl/mips_pkg.sv
// mips_pkg: shared types, defaults and PC helper for the mips_cpu_harvard fetch path.
package mips_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FS_RUN, FS_HALTED, FS_FAULT} fetch_state_t;
    localparam word_t RESET_VECTOR_DEF = 32'hBFC0_0000;
    localparam word_t HALT_ADDR_DEF    = 32'h0000_0000;
    localparam int    INSTR_BYTES      = 4;
    function automatic word_t next_pc(input word_t pc, input logic redirect, input word_t target);
        return redirect ? target : pc + word_t'(INSTR_BYTES);
    endfunction
endpackage

// File: rtl/mips_if_id_reg.sv
// mips_if_id_reg: IF/ID pipeline register; load captures a fetched instruction, clear drops valid.
module mips_if_id_reg
    import mips_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  i_load,
    input  logic  i_clear,
    input  word_t i_instr,
    input  word_t i_pc,
    output logic  o_valid,
    output word_t o_instr,
    output word_t o_pc
);
    logic  r_valid;
    word_t r_instr;
    word_t r_pc;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end
    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;
endmodule

// File: rtl/mips_fetch_stage.sv
// mips_fetch_stage: PC, IF/ID register, delay-slot redirects and halt detection.
// Optional misaligned-fetch trap enabled by defining FETCH_ALIGN_CHECK_EN.
module mips_fetch_stage
    import mips_pkg::*;
#(
    parameter word_t RESET_VECTOR = RESET_VECTOR_DEF,
    parameter word_t HALT_ADDR    = HALT_ADDR_DEF
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  clk_enable,
    input  logic  stall,
    input  logic  redirect_valid,
    input  word_t redirect_pc,
    output word_t instr_address,
    input  word_t instr_readdata,
    output logic  if_valid,
    output word_t if_instr,
    output word_t if_pc,
    output logic  fetch_done,
    output word_t fetch_count,
    output logic  fetch_fault
);
    fetch_state_t r_state, w_state_nxt;
    word_t r_pc;
    word_t r_count;
    logic  r_done;
    logic  w_run, w_halt, w_misalign, w_adv;

    assign w_run  = clk_enable && (r_state == FS_RUN);
    // Halt wins over stall so a stalled core fetching HALT_ADDR still terminates.
    assign w_halt = w_run && (r_pc == HALT_ADDR);
`ifdef FETCH_ALIGN_CHECK_EN
    logic r_fault;
    assign w_misalign = w_run && !w_halt && (r_pc[1:0] != 2'b00);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_fault <= 1'b0;
        else if (w_misalign)
            r_fault <= 1'b1;
    end
    assign fetch_fault = r_fault;
`else
    assign w_misalign  = 1'b0;
    assign fetch_fault = 1'b0;
`endif
    assign w_adv = w_run && !stall && !w_halt && !w_misalign;

    always_comb begin
        w_state_nxt = r_state;
        w_state_nxt = w_halt ? FS_HALTED : w_misalign ? FS_FAULT : r_state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= FS_RUN;
        else
            r_state <= w_state_nxt;
    end

    // The delay slot at pc+4 is fetched on the same edge decode presents the redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc    <= RESET_VECTOR;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            if (w_adv) begin
                r_pc    <= next_pc(r_pc, redirect_valid, redirect_pc);
                r_count <= r_count + 32'd1;
            end
            if (w_halt || w_misalign)
                r_done <= 1'b1;
        end
    end

    mips_if_id_reg u_if_id (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_adv),
        .i_clear (w_halt || w_misalign),
        .i_instr (instr_readdata),
        .i_pc    (r_pc),
        .o_valid (if_valid),
        .o_instr (if_instr),
        .o_pc    (if_pc)
    );

    assign instr_address = r_pc;
    assign fetch_done    = r_done;
    assign fetch_count   = r_count;
endmodule
